tm1638_key_event: RTL

TM1638_KEY_EVENT -- requirements
Module: tm1638_key_event

---
 rtl/tm1638_key_pkg.sv | 19 +
 rtl/tm1638_key_fifo.sv | 70 +++++++
 rtl/tm1638_key_event.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/tm1638_key_pkg.sv
// rtl/tm1638_key_pkg.sv - shared constants for the TM1638 key event block
//
// Purpose: event-kind encodings, key count, event word width and a packing
// helper shared by tm1638_key_event and tm1638_key_fifo.

package tm1638_key_pkg;

  localparam int NUM_KEYS = 8;
  localparam int EV_W     = 5;

  localparam logic [1:0] KIND_REL = 2'b00;
  localparam logic [1:0] KIND_PRS = 2'b01;
  localparam logic [1:0] KIND_REP = 2'b10;

  function automatic logic [EV_W-1:0] ev_pack(input logic [1:0] kind, input logic [2:0] idx);
    return {kind, idx};
  endfunction

endpackage

// File: rtl/tm1638_key_fifo.sv
// rtl/tm1638_key_fifo.sv - synchronous valid/ready event FIFO
//
// Purpose: DEPTH-entry FIFO; pointers carry one extra wrap bit so that
// occupancy is wr - rd. A push is accepted when full if a pop happens in the
// same cycle, so a full FIFO with a draining consumer never stalls.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_tdata/tvalid/tready   write side
//   out_tdata/tvalid/tready  read side; out_tdata reads 0 while empty

module tm1638_key_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_tdata,
  input  logic             in_tvalid,
  output logic             in_tready,
  output logic [WIDTH-1:0] out_tdata,
  output logic             out_tvalid,
  input  logic             out_tready
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW:0]      count;
  logic             push, pop, empty, full;

  always_comb begin
    count      = wr_ptr_q - rd_ptr_q;
    empty      = (count == '0);
    full       = (count == FULL_CNT);
    out_tvalid = !empty;
    pop        = out_tvalid && out_tready;
    in_tready  = !full || pop;
    push       = in_tvalid && in_tready;
    out_tdata  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    wr_ptr_d   = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = in_tdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: out_tdata is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/tm1638_key_event.sv
// rtl/tm1638_key_event.sv - debounced key levels and press/release/repeat events
//
// Purpose: registers raw TM1638 key levels, debounces each key on a 1 ms tick,
// turns stable edges into pending events and pushes one event per cycle into
// an event FIFO (release > press > repeat, then lowest key index).
// Optional auto-repeat: define TM1638_KEY_AUTO_REPEAT_EN.
// Ports:
//   CK_i, XARST_i    clock, asynchronous active-low reset
//   KEYS_i[7:0]      raw key levels, 1 = pressed
//   KEYS_STB_o[7:0]  debounced key levels
//   EV_VALID_o / EV_READY_i / EV_DAT_o[4:0]  event stream {kind[1:0], key[2:0]}
//   OVF_o            sticky: an event arrived while its pending flag was set

module tm1638_key_event
  import tm1638_key_pkg::*;
#(
  parameter int C_FCK        = 48_000_000,
  parameter int C_DEB_MS     = 20,
  parameter int C_REP_DLY_MS = 500,
  parameter int C_REP_MS     = 100,
  parameter int C_FIFO_DEPTH = 4
) (
  input  logic            CK_i,
  input  logic            XARST_i,
  input  logic [7:0]      KEYS_i,
  output logic [7:0]      KEYS_STB_o,
  output logic            EV_VALID_o,
  input  logic            EV_READY_i,
  output logic [EV_W-1:0] EV_DAT_o,
  output logic            OVF_o
);

  localparam int TICK_DIV = C_FCK / 1000;
  localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [7:0] DEB_LAST = 8'(C_DEB_MS - 1);

  if (C_DEB_MS < 1 || C_DEB_MS > 255) begin : g_bad_deb
    $error("C_DEB_MS must be 1..255");
  end
  if (C_REP_DLY_MS < 1 || C_REP_MS < 1) begin : g_bad_rep
    $error("repeat timings must be at least 1 ms");
  end

  logic [7:0]        keys_q, keys_d;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic              tick;
  logic [7:0]        stb_q, stb_d;
  logic [7:0]        stb_dly_q, stb_dly_d;
  logic [7:0]        deb_cnt_q [NUM_KEYS];
  logic [7:0]        deb_cnt_d [NUM_KEYS];
  logic [7:0]        prs_pend_q, prs_pend_d, rel_pend_q, rel_pend_d;
  logic [7:0]        prs_set, rel_set, prs_clr, rel_clr, rep_clr, rep_pend;
  logic              rep_ovf;
  logic              ovf_q, ovf_d;
  logic              sel_valid, push, fifo_in_tready;
  logic [1:0]        sel_kind;
  logic [2:0]        sel_idx;

  // Tick and per-key debounce: a key flips only after C_DEB_MS consecutive
  // ticks of disagreement; any agreement restarts the count.
  always_comb begin
    keys_d     = KEYS_i;
    tick       = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
    stb_d      = stb_q;
    stb_dly_d  = stb_q;
    for (int k = 0; k < NUM_KEYS; k++) begin
      deb_cnt_d[k] = deb_cnt_q[k];
      if (keys_q[k] == stb_q[k]) begin
        deb_cnt_d[k] = '0;
      end else if (tick) begin
        if (deb_cnt_q[k] == DEB_LAST) begin
          stb_d[k]     = ~stb_q[k];
          deb_cnt_d[k] = '0;
        end else begin
          deb_cnt_d[k] = deb_cnt_q[k] + 8'd1;
        end
      end
    end
  end

  // Edges are taken against a delayed copy so events lag the debounced level
  // by one register, giving EV_VALID_o two clocks after KEYS_STB_o changes.
  always_comb begin
    prs_set = stb_q & ~stb_dly_q;
    rel_set = ~stb_q & stb_dly_q;
  end

  // Later loops override earlier ones, and each loop runs downward so the
  // lowest index wins: release > press > repeat, then lowest key.
  always_comb begin
    sel_valid = 1'b0;
    sel_kind  = KIND_REL;
    sel_idx   = '0;
    for (int k = NUM_KEYS - 1; k >= 0; k--) begin
      if (rep_pend[k]) begin
        sel_valid = 1'b1;
        sel_kind  = KIND_REP;
        sel_idx   = 3'(k);
      end
    end
    for (int k = NUM_KEYS - 1; k >= 0; k--) begin
      if (prs_pend_q[k]) begin
        sel_valid = 1'b1;
        sel_kind  = KIND_PRS;
        sel_idx   = 3'(k);
      end
    end
    for (int k = NUM_KEYS - 1; k >= 0; k--) begin
      if (rel_pend_q[k]) begin
        sel_valid = 1'b1;
        sel_kind  = KIND_REL;
        sel_idx   = 3'(k);
      end
    end
  end

  always_comb begin
    push       = sel_valid && fifo_in_tready;
    prs_clr    = (push && sel_kind == KIND_PRS) ? (8'b1 << sel_idx) : 8'b0;
    rel_clr    = (push && sel_kind == KIND_REL) ? (8'b1 << sel_idx) : 8'b0;
    rep_clr    = (push && sel_kind == KIND_REP) ? (8'b1 << sel_idx) : 8'b0;
    prs_pend_d = (prs_pend_q & ~prs_clr) | prs_set;
    rel_pend_d = (rel_pend_q & ~rel_clr) | rel_set;
    // A flag being pushed this cycle is free to take the new event.
    ovf_d      = ovf_q | (|(prs_set & prs_pend_q & ~prs_clr))
                       | (|(rel_set & rel_pend_q & ~rel_clr)) | rep_ovf;
  end

`ifdef TM1638_KEY_AUTO_REPEAT_EN
  localparam int REP_MAX = (C_REP_DLY_MS > C_REP_MS) ? C_REP_DLY_MS : C_REP_MS;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  localparam logic [REP_W-1:0] DLY_LAST = REP_W'(C_REP_DLY_MS - 1);
  localparam logic [REP_W-1:0] PER_LAST = REP_W'(C_REP_MS - 1);

  logic [7:0]       rep_pend_q, rep_pend_d, rep_set;
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic [2:0]       rep_key_q, rep_key_d, low_idx;
  logic             rep_arm_q, rep_arm_d, rep_first_q, rep_first_d;

  // The timer follows only the lowest held key; losing or changing it restarts
  // the initial delay.
  always_comb begin
    low_idx = '0;
    for (int k = NUM_KEYS - 1; k >= 0; k--) begin
      if (stb_q[k]) low_idx = 3'(k);
    end
    rep_set     = '0;
    rep_cnt_d   = rep_cnt_q;
    rep_key_d   = rep_key_q;
    rep_arm_d   = rep_arm_q;
    rep_first_d = rep_first_q;
    if (!(|stb_q) || !rep_arm_q || low_idx != rep_key_q) begin
      rep_arm_d   = |stb_q;
      rep_key_d   = low_idx;
      rep_cnt_d   = '0;
      rep_first_d = 1'b1;
    end else if (tick) begin
      if (rep_cnt_q == (rep_first_q ? DLY_LAST : PER_LAST)) begin
        rep_set     = 8'b1 << rep_key_q;
        rep_cnt_d   = '0;
        rep_first_d = 1'b0;
      end else begin
        rep_cnt_d = rep_cnt_q + REP_W'(1);
      end
    end
    rep_pend_d = (rep_pend_q & ~rep_clr) | rep_set;
    rep_ovf    = |(rep_set & rep_pend_q & ~rep_clr);
    rep_pend   = rep_pend_q;
  end

  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      rep_pend_q  <= '0;
      rep_cnt_q   <= '0;
      rep_key_q   <= '0;
      rep_arm_q   <= 1'b0;
      rep_first_q <= 1'b1;
    end else begin
      rep_pend_q  <= rep_pend_d;
      rep_cnt_q   <= rep_cnt_d;
      rep_key_q   <= rep_key_d;
      rep_arm_q   <= rep_arm_d;
      rep_first_q <= rep_first_d;
    end
  end
`else
  always_comb begin
    rep_pend = '0;
    rep_ovf  = 1'b0;
  end
`endif

  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      keys_q     <= '0;
      tick_cnt_q <= '0;
      stb_q      <= '0;
      stb_dly_q  <= '0;
      prs_pend_q <= '0;
      rel_pend_q <= '0;
      ovf_q      <= 1'b0;
      for (int k = 0; k < NUM_KEYS; k++) deb_cnt_q[k] <= '0;
    end else begin
      keys_q     <= keys_d;
      tick_cnt_q <= tick_cnt_d;
      stb_q      <= stb_d;
      stb_dly_q  <= stb_dly_d;
      prs_pend_q <= prs_pend_d;
      rel_pend_q <= rel_pend_d;
      ovf_q      <= ovf_d;
      for (int k = 0; k < NUM_KEYS; k++) deb_cnt_q[k] <= deb_cnt_d[k];
    end
  end

  tm1638_key_fifo #(
    .DEPTH(C_FIFO_DEPTH),
    .WIDTH(EV_W)
  ) u_fifo (
    .clk       (CK_i),
    .rst_n     (XARST_i),
    .in_tdata  (ev_pack(sel_kind, sel_idx)),
    .in_tvalid (sel_valid),
    .in_tready (fifo_in_tready),
    .out_tdata (EV_DAT_o),
    .out_tvalid(EV_VALID_o),
    .out_tready(EV_READY_i)
  );

  assign KEYS_STB_o = stb_q;
  assign OVF_o      = ovf_q;

endmodule
